// File: rtl/mem_access_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states, default memory limit.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_e;

    localparam int ADDR_LIMIT_DEF = 256;

    function automatic logic [2:0] size_bytes(input size_e s);
        case (s)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte/half lane extract+extend for loads and lane merge for sub-word stores.
// Purely combinational, zero latency, no flow control.
module mem_lane import mem_access_pkg::*; #(
    parameter int N = 32
) (
    input  logic [N-1:0] rdata_i,
    input  logic [1:0]   addr_lo_i,
    input  size_e        size_i,
    input  logic         unsigned_i,
    input  logic [15:0]  wdata_i,
    output logic [N-1:0] load_o,
    output logic [N-1:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        load_o   = rdata_i;
        merge_o  = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = unsigned_i ? {{(N-8){1'b0}}, byte_sel}
                                    : {{(N-8){byte_sel[7]}}, byte_sel};
                merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o = unsigned_i ? {{(N-16){1'b0}}, half_sel}
                                    : {{(N-16){half_sel[15]}}, half_sel};
                merge_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit over a word-wide async-read RAM; resp at T+1 (error), T+2 (load/SW), T+3 (SB/SH).
// Accepts one request only in IDLE (req_ready); response is a single unthrottled pulse.
module mem_access_unit import mem_access_pkg::*; #(
    parameter int N          = 32,
    parameter int ADDR_LIMIT = ADDR_LIMIT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err,
    output logic [N-1:0] mem_addr,
    output logic         mem_we,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
);

    localparam logic [N:0] LIMIT = (N+1)'(ADDR_LIMIT);

    state_e       state_q, state_d;
    logic [N-1:0] addr_q, mem_wdata_q, resp_rdata_q;
    size_e        size_q;
    logic         we_q, unsigned_q, resp_valid_q, resp_err_q;

    size_e        req_sz;
    logic         hs, misalign, req_err;
    logic [N:0]   end_addr;
    logic [N-1:0] lane_load, lane_merge;

    assign req_sz = size_e'(req_size);
    assign hs     = req_valid & req_ready;

    // Range check is done one bit wider so an address near the top cannot wrap past the limit.
    always_comb begin
        end_addr = {1'b0, req_addr} + (N+1)'(size_bytes(req_sz));
        case (req_sz)
            SZ_HALF: misalign = req_addr[0];
            SZ_WORD: misalign = |req_addr[1:0];
            SZ_ILL:  misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
        req_err = misalign | (end_addr > LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) begin
                if (req_err)                state_d = RESP;
                else if (!req_we)           state_d = RD;
                else if (req_sz == SZ_WORD) state_d = WR;
                else                        state_d = RD;
            end
            RD:      state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst_n keeps a reset asserted mid-WR from committing the write.
    always_comb begin
        req_ready = (state_q == IDLE);
        mem_we    = (state_q == WR) & rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q       <= '0;
            size_q       <= SZ_BYTE;
            we_q         <= 1'b0;
            unsigned_q   <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= (state_d == RESP);
            if (hs) begin
                addr_q       <= req_addr;
                size_q       <= req_sz;
                we_q         <= req_we;
                unsigned_q   <= req_unsigned;
                mem_wdata_q  <= req_wdata;
                resp_err_q   <= req_err;
                resp_rdata_q <= '0;
            end
            if (state_q == RD) begin
                if (we_q) mem_wdata_q  <= lane_merge;
                else      resp_rdata_q <= lane_load;
            end
        end
    end

    mem_lane #(.N(N)) u_lane (
        .rdata_i    (mem_rdata),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (unsigned_q),
        .wdata_i    (mem_wdata_q[15:0]),
        .load_o     (lane_load),
        .merge_o    (lane_merge)
    );

    assign mem_addr   = {addr_q[N-1:2], 2'b00};
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter N, default 32, meaning data and address width.
REQ-002 SHALL have parameter ADDR_LIMIT, default 256, meaning the first illegal byte address of the data memory.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1, meaning a request is present.
REQ-006 SHALL have port req_ready, output, 1, meaning the unit accepts a request this cycle.
REQ-007 SHALL have port req_we, input, 1, meaning store (1) or load (0).
REQ-008 SHALL have port req_size, input, 2, encoded 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned, input, 1, meaning zero-extend instead of sign-extend on loads.
REQ-010 SHALL have port req_addr, input, N, the byte address.
REQ-011 SHALL have port req_wdata, input, N, the store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1, a one-cycle completion pulse with no backpressure.
REQ-013 SHALL have port resp_rdata, output, N, the extended load result.
REQ-014 SHALL have port resp_err, output, 1, an error flag qualified by resp_valid.
REQ-015 SHALL have port mem_addr, output, N, to the memory Address, always word-aligned.
REQ-016 SHALL have port mem_we, output, 1, to the memory WE; the memory writes on negedge when WE is high.
REQ-017 SHALL have port mem_wdata, output, N, to the memory data, little-endian.
REQ-018 SHALL have port mem_rdata, input, N, from the memory dataout, an asynchronous read.

Function
REQ-019 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-020 SHALL, on handshake (req_valid & req_ready), register addr/size/we/unsigned/wdata and drive mem_addr={addr[N-1:2],2'b00} from the register until the next acceptance.
REQ-021 SHALL flag an error on handshake when size=11, when a half access has addr[0]=1, when a word access has addr[1:0]!=0, or when addr+bytes>ADDR_LIMIT.
REQ-022 SHALL, on error, go IDLE->RESP: resp_valid at T+1, resp_err=1, resp_rdata=0, and no mem_we at any point.
REQ-023 SHALL handle a load as IDLE->RD->RESP: sample mem_rdata at the end of RD; resp_valid at T+2, where T is the handshake cycle.
REQ-024 SHALL, on load, select byte lane addr[1:0] or half lane addr[1] and extend to N bits per req_unsigned; word loads pass through unmodified.
REQ-025 SHALL handle a word store as IDLE->WR->RESP: mem_wdata=wdata and mem_we=1 for exactly the WR cycle; resp_valid at T+2.
REQ-026 SHALL handle a sub-word store as IDLE->RD->WR->RESP: in RD, read the word and replace only the target lane with wdata[7:0] or wdata[15:0]; write in WR; resp_valid at T+3.
REQ-027 SHALL drive resp_rdata=0 for stores, with resp_err=0.
REQ-028 SHALL go RESP->IDLE unconditionally, so back-to-back requests are one per 3/3/4 cycles (load / word store / sub-word store).
REQ-029 SHALL drive mem_we as (state==WR) & rst_n, so that no memory write occurs in any cycle with rst_n low.

Reset
REQ-030 SHALL, while rst_n is low at posedge, set state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, and all request registers=0.
REQ-031 SHALL, when reset hits mid-operation, abandon the operation with no response pulse; an interrupted sub-word store SHALL leave memory unmodified.

Structure
REQ-032 SHALL place in shared package mem_access_pkg: the size encodings, the FSM state enum, and the ADDR_LIMIT default.
REQ-033 SHALL implement lane extraction/extension and lane merge in combinational sub-module mem_lane, instantiated once.

Verification
REQ-034 SHALL cover: word 0x10=0x80FF7F01; LB 0x11 -> 0x0000007F; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF; each with resp_valid at T+2.
REQ-035 SHALL cover: SB 0x12, wdata 0x000000AB -> one mem_we cycle at T+2; word 0x10 becomes 0x80AB7F01; resp_valid at T+3.
REQ-036 SHALL cover: SW 0x20, wdata 0xDEADBEEF -> mem_we at T+1 only; subsequent LW 0x20 -> 0xDEADBEEF.
REQ-037 SHALL cover: LW 0x12, SH 0x13, LB 0x100, and size=11 -> resp_err=1 at T+1; mem_we never asserted.
REQ-038 SHALL cover: SW 0x30, wdata 0x12345678, with rst_n low during WR -> no write; word 0x30 unchanged; no resp_valid; req_ready=1 the cycle after reset releases.
